// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus bundle: fetch-side instruction handshake, ALU-side operand
// bundle handshake, and the register/flag writeback return path.
//   master : fetch/ALU/writeback environment (drives instructions, out_ready, writebacks)
//   slave  : alu_operand_stage (drives in_ready and the operand bundle)
interface alu_operand_stage_if #(
  parameter int unsigned AW = 3
);
  logic                 in_valid;
  logic [31:0]          in_instr;
  logic                 in_ready;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [31:0]   out_reg1;
  logic signed [31:0]   out_reg2;
  logic [15:0]          out_iv;
  logic [3:0]           out_opcode;
  logic [3:0]           out_cond;
  logic                 out_s;
  logic [3:0]           out_flag;
  logic [AW-1:0]        out_rd;

  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [31:0]          wb_data;
  logic                 flag_we;
  logic [3:0]           new_flag;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data, flag_we, new_flag,
    input  in_ready, out_valid, out_reg1, out_reg2, out_iv, out_opcode, out_cond,
           out_s, out_flag, out_rd
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data, flag_we, new_flag,
    output in_ready, out_valid, out_reg1, out_reg2, out_iv, out_opcode, out_cond,
           out_s, out_flag, out_rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage ahead of the ALU. Decodes the instruction word,
// reads the 8x32 register file with writeback bypass, tracks pending register
// and flag writes, stalls on hazards and holds a registered operand bundle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_operand_stage_if.slave: instruction in (valid/ready), operand
//          bundle out (valid/ready), register and flag writeback inputs
module alu_operand_stage #(
  parameter int unsigned NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_stage_if.slave   bus
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 4;
  localparam int unsigned IW = 16;

  // Architectural state and scoreboard
  logic [DW-1:0]   rf_q [NREG];
  logic [FW-1:0]   flag_q;
  logic [NREG-1:0] pend_q;
  logic            fpend_q;

  // Output bundle registers
  logic            valid_q;
  logic [DW-1:0]   reg1_q;
  logic [DW-1:0]   reg2_q;
  logic [IW-1:0]   iv_q;
  logic [3:0]      opcode_q;
  logic [3:0]      cond_q;
  logic            s_q;
  logic [FW-1:0]   oflag_q;
  logic [AW-1:0]   rd_q;

  // Instruction field decode
  logic [3:0]    opcode;
  logic [3:0]    cond;
  logic          s;
  logic [AW-1:0] rd;
  logic [AW-1:0] rn;
  logic [AW-1:0] rm;
  logic [IW-1:0] iv;
  logic          unused_bits;

  assign opcode      = bus.in_instr[31:28];
  assign cond        = bus.in_instr[27:24];
  assign s           = bus.in_instr[23];
  assign rd          = bus.in_instr[20 +: AW];
  assign rn          = bus.in_instr[17 +: AW];
  assign iv          = bus.in_instr[15:0];
  assign rm          = iv[AW-1:0];
  assign unused_bits = bus.in_instr[16];

  // Opcode classes
  logic uses_rn;
  logic uses_rm;
  logic writes_rd;

  always_comb begin
    uses_rn   = !(opcode inside {4'b0110, 4'b0111, 4'b1111});
    uses_rm   = (opcode <= 4'b0101) || (opcode == 4'b0111) || (opcode == 4'b1011);
    writes_rd = (opcode <= 4'b1010) || (opcode == 4'b1100) || (opcode == 4'b1101);
  end

  // Register reads with same-cycle writeback bypass
  logic          rn_wb_hit;
  logic          rm_wb_hit;
  logic [DW-1:0] rn_data;
  logic [DW-1:0] rm_data;
  logic [FW-1:0] flag_data;

  assign rn_wb_hit = bus.wb_en && (bus.wb_addr == rn);
  assign rm_wb_hit = bus.wb_en && (bus.wb_addr == rm);
  assign rn_data   = rn_wb_hit ? bus.wb_data : rf_q[rn];
  assign rm_data   = rm_wb_hit ? bus.wb_data : rf_q[rm];
  assign flag_data = bus.flag_we ? bus.new_flag : flag_q;

  // Hazard detection: a pending source is resolved only by its writeback this cycle;
  // conditional instructions always wait for outstanding flags to land.
  logic hazard;
  logic issue;

  always_comb begin
    hazard = 1'b0;
    if (bus.in_valid) begin
      if (uses_rn && pend_q[rn] && !rn_wb_hit) hazard = 1'b1;
      if (uses_rm && pend_q[rm] && !rm_wb_hit) hazard = 1'b1;
      if (fpend_q && (!bus.flag_we || (cond != 4'b0000))) hazard = 1'b1;
    end
  end

  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard;
  assign issue        = bus.in_valid && bus.in_ready;

  // Scoreboard next state: clears from writeback first so a same-cycle set wins
  logic [NREG-1:0] pend_nxt;
  logic            fpend_nxt;

  always_comb begin
    pend_nxt  = pend_q;
    fpend_nxt = fpend_q;
    if (bus.wb_en)           pend_nxt[bus.wb_addr] = 1'b0;
    if (issue && writes_rd)  pend_nxt[rd]          = 1'b1;
    if (bus.flag_we)         fpend_nxt             = 1'b0;
    if (issue && s)          fpend_nxt             = 1'b1;
  end

  // State, register file and output bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      flag_q   <= '0;
      pend_q   <= '0;
      fpend_q  <= 1'b0;
      valid_q  <= 1'b0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      iv_q     <= '0;
      opcode_q <= '0;
      cond_q   <= '0;
      s_q      <= 1'b0;
      oflag_q  <= '0;
      rd_q     <= '0;
    end else begin
      if (bus.wb_en)   rf_q[bus.wb_addr] <= bus.wb_data;
      if (bus.flag_we) flag_q            <= bus.new_flag;
      pend_q  <= pend_nxt;
      fpend_q <= fpend_nxt;
      if (issue) begin
        valid_q  <= 1'b1;
        reg1_q   <= rn_data;
        reg2_q   <= rm_data;
        iv_q     <= iv;
        opcode_q <= opcode;
        cond_q   <= cond;
        s_q      <= s;
        oflag_q  <= flag_data;
        rd_q     <= rd;
      end else if (bus.out_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_reg1   = reg1_q;
  assign bus.out_reg2   = reg2_q;
  assign bus.out_iv     = iv_q;
  assign bus.out_opcode = opcode_q;
  assign bus.out_cond   = cond_q;
  assign bus.out_s      = s_q;
  assign bus.out_flag   = oflag_q;
  assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected bundles are queued at issue
// from a small register/flag model and checked when the ALU side consumes them.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.NREG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [15:0] iv;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  flag;
    logic [2:0]  rd;
  } bundle_t;

  bundle_t     exp_q[$];
  bundle_t     mon_e;
  logic [31:0] m_rf [8];
  logic [3:0]  m_flag;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] cond,
                                     input logic s, input logic [2:0] rd,
                                     input logic [2:0] rn, input logic [15:0] iv);
    return {op, cond, s, rd, rn, 1'b0, iv};
  endfunction

  function automatic logic [31:0] byp(input logic [2:0] a);
    return (bus.wb_en && bus.wb_addr == a) ? bus.wb_data : m_rf[a];
  endfunction

  // Advance one clock, applying this cycle's writebacks (or reset) to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_flag = '0;
    end else begin
      if (bus.wb_en)   m_rf[bus.wb_addr] = bus.wb_data;
      if (bus.flag_we) m_flag = bus.new_flag;
    end
    #1;
  endtask

  task automatic wb(input logic en, input logic [2:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  // Check in_ready for the presented instruction; queue its bundle if it issues
  task automatic try_issue(input string tag, input logic exp_ready);
    bundle_t     b;
    logic [31:0] ins;
    #1;
    chk(tag, 32'(bus.in_ready), 32'(exp_ready));
    if (exp_ready) begin
      ins      = bus.in_instr;
      b.reg1   = byp(ins[19:17]);
      b.reg2   = byp(ins[2:0]);
      b.iv     = ins[15:0];
      b.opcode = ins[31:28];
      b.cond   = ins[27:24];
      b.s      = ins[23];
      b.flag   = bus.flag_we ? bus.new_flag : m_flag;
      b.rd     = ins[22:20];
      exp_q.push_back(b);
    end
  endtask

  // Consumed bundles are compared against the queue
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_bundle observed=opcode %h expected=no bundle", bus.out_opcode);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("reg1",   32'(bus.out_reg1),   mon_e.reg1);
        chk("reg2",   32'(bus.out_reg2),   mon_e.reg2);
        chk("iv",     32'(bus.out_iv),     32'(mon_e.iv));
        chk("opcode", 32'(bus.out_opcode), 32'(mon_e.opcode));
        chk("cond",   32'(bus.out_cond),   32'(mon_e.cond));
        chk("s",      32'(bus.out_s),      32'(mon_e.s));
        chk("flag",   32'(bus.out_flag),   32'(mon_e.flag));
        chk("rd",     32'(bus.out_rd),     32'(mon_e.rd));
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flag       = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b1;
    bus.flag_we  = 1'b0;
    bus.new_flag = '0;
    wb(1'b0, 3'd0, 32'd0);

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_reg1",  32'(bus.out_reg1),  32'd0);
    chk("rst_out_reg2",  32'(bus.out_reg2),  32'd0);
    chk("rst_out_iv",    32'(bus.out_iv),    32'd0);
    chk("rst_out_flag",  32'(bus.out_flag),  32'd0);
    chk("rst_out_rd",    32'(bus.out_rd),    32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset then ADD
    wb(1'b1, 3'd1, 32'h6000_0000);
    tick();
    wb(1'b1, 3'd2, 32'h2000_0001);
    tick();
    wb(1'b0, 3'd0, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'b0000, 4'b0000, 1'b1, 3'd3, 3'd1, 16'h0002);
    try_issue("add_ready", 1'b1);
    tick();
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);

    // Flag stall: conditional OR waits for the ADD flags
    bus.in_instr = mk(4'b1001, 4'b0010, 1'b0, 3'd5, 3'd1, 16'h0003);
    try_issue("flag_stall_0", 1'b0);
    tick();
    try_issue("flag_stall_1", 1'b0);
    tick();
    bus.flag_we  = 1'b1;
    bus.new_flag = 4'b1001;
    try_issue("flag_stall_we", 1'b0);
    tick();
    bus.flag_we  = 1'b0;
    try_issue("flag_release", 1'b1);
    tick();
    bus.in_valid = 1'b0;

    // Retire ADD and OR results, preload r7
    wb(1'b1, 3'd3, 32'h8000_0001);
    tick();
    wb(1'b1, 3'd5, 32'h6000_0003);
    tick();
    wb(1'b1, 3'd7, 32'd7);
    tick();
    wb(1'b0, 3'd0, 32'd0);

    // RAW stall: MUL r4 <- r7*r7, then XOR reading r4
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'b0010, 4'b0000, 1'b0, 3'd4, 3'd7, 16'h0007);
    try_issue("mul_ready", 1'b1);
    tick();
    bus.in_instr = mk(4'b0011, 4'b0000, 1'b0, 3'd6, 3'd4, 16'h0001);
    try_issue("raw_stall_0", 1'b0);
    tick();
    try_issue("raw_stall_1", 1'b0);
    tick();
    wb(1'b1, 3'd4, 32'd49);
    try_issue("raw_bypass", 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wb(1'b1, 3'd6, 32'h1234_5678);
    tick();
    wb(1'b0, 3'd0, 32'd0);

    // Backpressure: LSL held for three cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(4'b0100, 4'b0000, 1'b0, 3'd2, 3'd1, 16'h0005);
    try_issue("lsl_ready", 1'b1);
    tick();
    bus.in_valid = 1'b0;
    try_issue("bp_idle_ready", 1'b0);
    chk("bp_valid_0", 32'(bus.out_valid), 32'd1);
    chk("bp_iv_0",    32'(bus.out_iv),    32'd5);
    tick();
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'b0000, 4'b0000, 1'b0, 3'd7, 3'd1, 16'h0001);
    try_issue("bp_stall_1", 1'b0);
    chk("bp_iv_1",   32'(bus.out_iv),   32'd5);
    chk("bp_reg1_1", 32'(bus.out_reg1), 32'h6000_0000);
    tick();
    try_issue("bp_stall_2", 1'b0);
    chk("bp_opcode_2", 32'(bus.out_opcode), 32'd4);
    tick();
    bus.out_ready = 1'b1;
    try_issue("bp_release", 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wb(1'b1, 3'd2, 32'h0000_00A0);
    tick();
    wb(1'b1, 3'd7, 32'h0000_00B0);
    tick();
    wb(1'b0, 3'd0, 32'd0);

    // Non-writers: CMP and NOP leave no pending bits behind
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'b1011, 4'b0000, 1'b0, 3'd4, 3'd1, 16'h0002);
    try_issue("cmp_ready", 1'b1);
    tick();
    bus.in_instr = mk(4'b1111, 4'b0000, 1'b0, 3'd5, 3'd0, 16'h0000);
    try_issue("nop_ready", 1'b1);
    tick();
    bus.in_instr = mk(4'b0000, 4'b0000, 1'b0, 3'd1, 3'd4, 16'h0005);
    try_issue("after_nonwriters", 1'b1);
    tick();

    // Flag bypass: unconditional MOV issues during the flag writeback
    bus.in_instr = mk(4'b0001, 4'b0000, 1'b1, 3'd0, 3'd2, 16'h0007);
    try_issue("sub_s_ready", 1'b1);
    tick();
    bus.in_instr = mk(4'b0111, 4'b0000, 1'b0, 3'd6, 3'd0, 16'h0002);
    bus.flag_we  = 1'b1;
    bus.new_flag = 4'b0110;
    try_issue("mov_flag_bypass", 1'b1);
    tick();
    bus.flag_we  = 1'b0;
    bus.in_instr = mk(4'b0000, 4'b0000, 1'b0, 3'd5, 3'd0, 16'h0002);
    try_issue("r0_pending_stall", 1'b0);
    tick();
    bus.in_valid = 1'b0;

    // Mid-stream reset with a held bundle and pend[3] set
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(4'b1100, 4'b0000, 1'b0, 3'd3, 3'd2, 16'h0002);
    try_issue("pre_rst_issue", 1'b1);
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_queue", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    wb(1'b1, 3'd2, 32'h0000_DEAD);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    wb(1'b0, 3'd0, 32'd0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'b0000, 4'b0000, 1'b0, 3'd4, 3'd3, 16'h0002);
    try_issue("post_rst_r3", 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode/operand-fetch pipeline stage sitting directly upstream of MASTER_ALU. Accepts 32-bit instruction words from fetch, reads an 8x32 register file, and holds the architectural flag register (`[N,Z,C,V]`). It tracks pending register and flag writes with a scoreboard, stalls on hazards, and presents a registered operand bundle for the ALU: `Reg1`, `Reg2`, `IV`, `OpCode`, `Cond`, `S` and `Flag`. ALU results return on a writeback port.

## Interface
- `NREG`, 8, register-file depth; address width is log2(NREG)=3.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_instr`  in  32  instruction fields:
  - [31:28] OpCode, [27:24] Cond, [23] S, [22:20] Rd, [19:17] Rn, [16] reserved (ignored).
  - [15:0] IV; Rm = IV[2:0].
- `in_ready`  out  1  stage accepts `in_instr` this cycle.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  ALU/execute consumes the bundle.
- `out_reg1`, `out_reg2`  out  32  signed operands (Rn, Rm contents).
- `out_iv`  out  16  immediate.
- `out_opcode`, `out_cond`  out  4  passed through unchanged.
- `out_s`  out  1  passed through unchanged.
- `out_flag`  out  4  flag register value at issue.
- `out_rd`  out  3  destination register.
- `wb_en`  in  1  register writeback.
- `wb_addr`  in  3  register writeback address.
- `wb_data`  in  32  register writeback data.
- `flag_we`  in  1  flag writeback, driven from ALU `New_Flag`.
- `new_flag`  in  4  flag writeback value.

## Operation
- **Opcode classes:**
  - Reads Rn: every opcode except 0110 (MOVn), 0111 (MOV), 1111 (NOP).
  - Reads Rm: 0000–0101, 0111, 1011.
  - Writes Rd: 0000–1010, 1100, 1101.
  - No Rd write: 1011 (CMP), 1110, 1111.
- **Scoreboard:** `pend[7:0]` plus `fpend`.
  - On issue of a Rd-writer, set `pend[Rd]`.
  - On issue with S=1, set `fpend`.
  - `wb_en` clears `pend[wb_addr]`; `flag_we` clears `fpend`.
  - If a set and a clear hit the same bit in one cycle, the set wins.
- **Hazard:** asserted when `in_valid` and any of:
  - a used source register has `pend` set and is not being written back this cycle (`wb_en && wb_addr==src` resolves it);
  - `fpend` is set and `flag_we` is low;
  - `fpend` is set and `Cond != 0000`.
- **Ready:** `in_ready = (!out_valid || out_ready) && !hazard`. `in_ready` is combinational on `in_instr` and `in_valid`.
- **Issue** (`in_valid && in_ready`):
  - Load all `out_*` fields and set `out_valid`.
  - Operands use write-through bypass: a same-cycle `wb_en` to the read address supplies `wb_data`.
  - `out_flag` uses `new_flag` if `flag_we` is high, otherwise the flag register.
- **Drain:** `out_valid && out_ready` with no new issue clears `out_valid`.
- **Hold:** bundle fields hold while `out_valid && !out_ready`.
- **Register file and flags:** written on `wb_en` / `flag_we` regardless of stall state. The flag register stores `new_flag` verbatim.
- **Register r0:** an ordinary register, not hardwired.

## Timing
- Reset values:
  - `out_valid`=0 and all `out_*` data outputs 0.
  - Register file all 0, flag register 0000, `pend`=0, `fpend`=0.
  - `in_ready` reads 1 the cycle after reset deasserts.
- Latency: 1 cycle from the accepting edge to `out_valid`. Throughput is 1 instruction/cycle with no hazards and `out_ready` high.
- Writeback at edge k is visible to an instruction issuing in the same cycle via bypass, so there is no extra stall beyond the writeback cycle.
- Back-to-back writes to the same Rd: the second issue re-sets `pend`. The first writeback clears it, so the ALU path must return writebacks in order. This is a system requirement; the stage does not check it.
- `rst` asserted mid-stream: all state returns to reset values at the next edge. The in-flight bundle and pending bits are discarded, and writebacks in the reset cycle are ignored.
- `in_valid` low: no issue, no scoreboard set. `in_ready` still reflects output availability.

## Test plan
- **Reset then ADD:**
  - Stimulus: wb r1=0x60000000, r2=0x20000001; issue ADD (Op 0000, Rn=1, Rm=2, Rd=3, S=1).
  - Required: next cycle `out_valid`=1, `out_reg1`=0x60000000, `out_reg2`=0x20000001, `out_rd`=3, `out_flag`=0000.
- **RAW stall:**
  - Stimulus: issue MUL Rd=4 (regs 7,7), then XOR with Rn=4.
  - Required: `in_ready`=0 until `wb_en`/`wb_addr`=4/`wb_data`=49. In that same cycle XOR issues with `out_reg1`=49.
- **Flag stall:**
  - Stimulus: ADD S=1 issued, then OR with Cond=0010.
  - Required: stall until `flag_we`=1, `new_flag`=1001; OR bundle carries `out_flag`=1001.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 3 cycles with LSL IV=5 pending in the output register.
  - Required: `out_*` stable and `in_ready`=0; bundle drains and the next instruction issues on the edge where `out_ready`=1.
- **Non-writers:**
  - Stimulus: CMP then NOP.
  - Required: no `pend` bits set; a following instruction reading any register issues without stall.
- **Mid-stream reset:**
  - Stimulus: assert `rst` with `out_valid`=1 and `pend[3]`=1.
  - Required: next cycle `out_valid`=0; `in_ready`=1 for an instruction reading r3; r3 reads 0.
